vend_fsm_param: RTL and testbench

- Parametrised vending controller, successor to the fixed 1/2-unit machine.
- Accepts three coin denominations with configurable values and accumulates credit in a multi-bit register.
- Vends when credit reaches PRICE, then pays out change one unit per cycle under hopper flow control.
- Supports cancel/refund, and rejects coins while busy or on credit overflow. Sits behind the coin-synchroniser logic in the top-level wrapper.

---
 rtl/vend_pkg.sv | 17 +
 rtl/vend_fsm_param_if.sv | 26 ++
 rtl/vend_coin_arb.sv | 36 +++
 rtl/vend_fsm_param.sv | 115 +++++++++++
 tb/tb_vend_fsm_param.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state and coin-select types for the vending controller
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        CHANGE
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        A,
        B,
        C
    } coin_sel_t;

endpackage

// File: rtl/vend_fsm_param_if.sv
// rtl/vend_fsm_param_if.sv - coin/hopper handshake bundle between front end and vending controller
interface vend_fsm_param_if #(
    parameter int CREDIT_W = 4
);
    logic                coin_a;
    logic                coin_b;
    logic                coin_c;
    logic                cancel;
    logic                hopper_ready;
    logic                vend;
    logic                change_pulse;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport master (
        output coin_a, coin_b, coin_c, cancel, hopper_ready,
        input  vend, change_pulse, coin_reject, credit, busy
    );

    modport slave (
        input  coin_a, coin_b, coin_c, cancel, hopper_ready,
        output vend, change_pulse, coin_reject, credit, busy
    );

endinterface

// File: rtl/vend_coin_arb.sv
// rtl/vend_coin_arb.sv - priority coin select (c > b > a) and multi-coin flag
module vend_coin_arb
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 4,
    parameter int VAL_A    = 1,
    parameter int VAL_B    = 2,
    parameter int VAL_C    = 5
) (
    input  logic                i_coin_a,
    input  logic                i_coin_b,
    input  logic                i_coin_c,
    output coin_sel_t           o_sel,
    output logic [CREDIT_W-1:0] o_val,
    output logic                o_multi
);

    always_comb begin
        o_sel = NONE;
        o_val = '0;
        if (i_coin_c) begin
            o_sel = C;
            o_val = CREDIT_W'(VAL_C);
        end else if (i_coin_b) begin
            o_sel = B;
            o_val = CREDIT_W'(VAL_B);
        end else if (i_coin_a) begin
            o_sel = A;
            o_val = CREDIT_W'(VAL_A);
        end
    end

    // Any second coin in the same cycle loses arbitration and must be returned.
    assign o_multi = (i_coin_a & i_coin_b) | (i_coin_a & i_coin_c) | (i_coin_b & i_coin_c);

endmodule

// File: rtl/vend_fsm_param.sv
// rtl/vend_fsm_param.sv - parametrised vending controller: credit accumulation, vend, change payout
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 4,
    parameter int PRICE    = 3,
    parameter int VAL_A    = 1,
    parameter int VAL_B    = 2,
    parameter int VAL_C    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    vend_fsm_param_if.slave  bus
);

    localparam int MAX_CREDIT = (1 << CREDIT_W) - 1;

    if (CREDIT_W < 1 || CREDIT_W > 30) begin : g_bad_width
        $fatal(1, "vend_fsm_param: CREDIT_W out of range");
    end
    if (PRICE < 1 || PRICE > MAX_CREDIT) begin : g_bad_price
        $fatal(1, "vend_fsm_param: PRICE out of range");
    end
    if (VAL_A < 1 || VAL_A > MAX_CREDIT || VAL_B < 1 || VAL_B > MAX_CREDIT ||
        VAL_C < 1 || VAL_C > MAX_CREDIT) begin : g_bad_val
        $fatal(1, "vend_fsm_param: coin value out of range");
    end

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_vend;
    logic                r_change;
    logic                r_reject;

    coin_sel_t           w_sel;
    logic [CREDIT_W-1:0] w_val;
    logic                w_multi;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_rem;
    logic                w_overflow;
    logic                w_cancel;
    logic                w_accept;
    logic                w_reject;

    vend_coin_arb #(
        .CREDIT_W (CREDIT_W),
        .VAL_A    (VAL_A),
        .VAL_B    (VAL_B),
        .VAL_C    (VAL_C)
    ) u_arb (
        .i_coin_a (bus.coin_a),
        .i_coin_b (bus.coin_b),
        .i_coin_c (bus.coin_c),
        .o_sel    (w_sel),
        .o_val    (w_val),
        .o_multi  (w_multi)
    );

    // One extra bit so an overflowing coin is detected rather than wrapped.
    assign w_sum      = {1'b0, r_credit} + {1'b0, w_val};
    assign w_overflow = w_sum[CREDIT_W];
    assign w_rem      = w_sum[CREDIT_W-1:0] - CREDIT_W'(PRICE);
    assign w_cancel   = bus.cancel && (r_state == ACCUM);
    assign w_accept   = (w_sel != NONE) && (r_state != CHANGE) && !w_cancel && !w_overflow;
    assign w_reject   = w_multi || ((w_sel != NONE) && !w_accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_credit <= '0;
            r_vend   <= 1'b0;
            r_change <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_vend   <= 1'b0;
            r_change <= 1'b0;
            r_reject <= w_reject;
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_cancel) begin
                        r_state <= CHANGE;
                    end else if (w_accept) begin
                        if (w_sum >= (CREDIT_W+1)'(PRICE)) begin
                            r_vend   <= 1'b1;
                            r_credit <= w_rem;
                            r_state  <= (w_rem != '0) ? CHANGE : IDLE;
                        end else begin
                            r_credit <= w_sum[CREDIT_W-1:0];
                            r_state  <= ACCUM;
                        end
                    end
                end
                CHANGE: begin
                    if (r_credit == '0) begin
                        r_state <= IDLE;
                    end else if (bus.hopper_ready) begin
                        r_change <= 1'b1;
                        r_credit <= r_credit - 1'b1;
                        if (r_credit == CREDIT_W'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.vend         = r_vend;
    assign bus.change_pulse = r_change;
    assign bus.coin_reject  = r_reject;
    assign bus.credit       = r_credit;
    assign bus.busy         = (r_state == CHANGE);

endmodule

// File: tb/tb_vend_fsm_param.sv
// tb/tb_vend_fsm_param.sv - scoreboard bench for vend_fsm_param (default and 3-bit/PRICE=7 builds)
module tb_vend_fsm_param;

    logic clk;
    logic rst_n;

    vend_fsm_param_if #(.CREDIT_W(4)) bus  ();
    vend_fsm_param_if #(.CREDIT_W(3)) bus7 ();

    vend_fsm_param #(
        .CREDIT_W (4), .PRICE (3), .VAL_A (1), .VAL_B (2), .VAL_C (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    vend_fsm_param #(
        .CREDIT_W (3), .PRICE (7), .VAL_A (1), .VAL_B (2), .VAL_C (5)
    ) dut7 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus7.slave)
    );

    typedef struct {
        string tag;
        bit    sel;
        bit    vend;
        bit    chg;
        bit    rej;
        int    credit;
        bit    busy;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs on the selected DUT, queue the outputs expected after the edge,
    // then pop and compare once the edge has passed.
    task automatic cyc(input string tag, input bit sel,
                       input bit a, input bit b, input bit c, input bit cn, input bit hop,
                       input bit ev, input bit ec, input bit er, input int ecr, input bit eb);
        exp_t e;
        bus.coin_a  = 1'b0; bus.coin_b  = 1'b0; bus.coin_c  = 1'b0; bus.cancel  = 1'b0;
        bus7.coin_a = 1'b0; bus7.coin_b = 1'b0; bus7.coin_c = 1'b0; bus7.cancel = 1'b0;
        if (!sel) begin
            bus.coin_a = a; bus.coin_b = b; bus.coin_c = c; bus.cancel = cn; bus.hopper_ready = hop;
        end else begin
            bus7.coin_a = a; bus7.coin_b = b; bus7.coin_c = c; bus7.cancel = cn; bus7.hopper_ready = hop;
        end
        sb.push_back('{tag, sel, ev, ec, er, ecr, eb});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (!e.sel) begin
            chk({e.tag, ".vend"},   32'(bus.vend),         32'(e.vend));
            chk({e.tag, ".chg"},    32'(bus.change_pulse), 32'(e.chg));
            chk({e.tag, ".rej"},    32'(bus.coin_reject),  32'(e.rej));
            chk({e.tag, ".credit"}, 32'(bus.credit),       32'(e.credit));
            chk({e.tag, ".busy"},   32'(bus.busy),         32'(e.busy));
        end else begin
            chk({e.tag, ".vend"},   32'(bus7.vend),         32'(e.vend));
            chk({e.tag, ".chg"},    32'(bus7.change_pulse), 32'(e.chg));
            chk({e.tag, ".rej"},    32'(bus7.coin_reject),  32'(e.rej));
            chk({e.tag, ".credit"}, 32'(bus7.credit),       32'(e.credit));
            chk({e.tag, ".busy"},   32'(bus7.busy),         32'(e.busy));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".vend"},   32'(bus.vend),         32'd0);
        chk({tag, ".chg"},    32'(bus.change_pulse), 32'd0);
        chk({tag, ".rej"},    32'(bus.coin_reject),  32'd0);
        chk({tag, ".credit"}, 32'(bus.credit),       32'd0);
        chk({tag, ".busy"},   32'(bus.busy),         32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.coin_a  = 1'b0; bus.coin_b  = 1'b0; bus.coin_c  = 1'b0; bus.cancel  = 1'b0; bus.hopper_ready  = 1'b1;
        bus7.coin_a = 1'b0; bus7.coin_b = 1'b0; bus7.coin_c = 1'b0; bus7.cancel = 1'b0; bus7.hopper_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset7.credit", 32'(bus7.credit), 32'd0);
        rst_n = 1'b1;

        //    tag        sel  a  b  c cn hop   vend chg rej credit busy
        cyc("b1",       0,   0, 1, 0, 0, 1,   0,   0,  0,  2,     0);
        cyc("b_idle",   0,   0, 0, 0, 0, 1,   0,   0,  0,  2,     0);
        cyc("b2_vend",  0,   0, 1, 0, 0, 1,   1,   0,  0,  1,     1);
        cyc("b_chg",    0,   0, 0, 0, 0, 1,   0,   1,  0,  0,     0);
        cyc("b_done",   0,   0, 0, 0, 0, 1,   0,   0,  0,  0,     0);

        cyc("c_vend",   0,   0, 0, 1, 0, 0,   1,   0,  0,  2,     1);
        for (int i = 0; i < 3; i++)
            cyc("c_stall", 0, 0, 0, 0, 0, 0,  0,   0,  0,  2,     1);
        cyc("c_chg1",   0,   0, 0, 0, 0, 1,   0,   1,  0,  1,     1);
        cyc("c_chg2",   0,   0, 0, 0, 0, 1,   0,   1,  0,  0,     0);
        cyc("c_done",   0,   0, 0, 0, 0, 1,   0,   0,  0,  0,     0);

        cyc("x_a",      0,   1, 0, 0, 0, 1,   0,   0,  0,  1,     0);
        cyc("x_cancel", 0,   0, 0, 0, 1, 1,   0,   0,  0,  1,     1);
        cyc("x_refund", 0,   0, 0, 0, 0, 1,   0,   1,  0,  0,     0);
        cyc("x_idlecn", 0,   0, 0, 0, 1, 1,   0,   0,  0,  0,     0);
        cyc("y_a",      0,   1, 0, 0, 0, 1,   0,   0,  0,  1,     0);
        cyc("y_cn_b",   0,   0, 1, 0, 1, 1,   0,   0,  1,  1,     1);
        cyc("y_refund", 0,   0, 0, 0, 0, 1,   0,   1,  0,  0,     0);

        cyc("m_ab",     0,   1, 1, 0, 0, 1,   0,   0,  1,  2,     0);
        cyc("m_a_vend", 0,   1, 0, 0, 0, 1,   1,   0,  0,  0,     0);

        cyc("bz_c",     0,   0, 0, 1, 0, 0,   1,   0,  0,  2,     1);
        cyc("bz_rej",   0,   1, 0, 0, 1, 0,   0,   0,  1,  2,     1);
        cyc("bz_chg1",  0,   0, 0, 0, 0, 1,   0,   1,  0,  1,     1);
        cyc("bz_chg2",  0,   0, 0, 0, 0, 1,   0,   1,  0,  0,     0);

        cyc("w7_c1",    1,   0, 0, 1, 0, 1,   0,   0,  0,  5,     0);
        cyc("w7_ovf",   1,   0, 0, 1, 0, 1,   0,   0,  1,  5,     0);
        cyc("w7_b",     1,   0, 1, 0, 0, 1,   1,   0,  0,  0,     0);
        cyc("w7_done",  1,   0, 0, 0, 0, 1,   0,   0,  0,  0,     0);

        cyc("r_a",      0,   1, 0, 0, 0, 1,   0,   0,  0,  1,     0);
        cyc("r_c_vend", 0,   0, 0, 1, 0, 0,   1,   0,  0,  3,     1);
        cyc("r_stall",  0,   0, 0, 0, 0, 0,   0,   0,  0,  3,     1);
        bus.hopper_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("r_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("r_post1",  0,   0, 0, 0, 0, 1,   0,   0,  0,  0,     0);
        cyc("r_post2",  0,   0, 0, 0, 0, 1,   0,   0,  0,  0,     0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
